// File: rtl/smvm_pkg.sv
// Shared SMVM definitions: datapath widths, output saturation limits and the
// row-accumulator state encoding used by the core top level.
package smvm_pkg;

    localparam int PSUM_W = 16;
    localparam int ACC_W  = 22;
    localparam int OUT_W  = 15;

    localparam logic signed [OUT_W-1:0] OUT_MAX = OUT_W'(16383);
    localparam logic signed [OUT_W-1:0] OUT_MIN = OUT_W'(-16384);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } smvm_state_e;

endpackage

// File: rtl/smvm_out_fifo.sv
// Small synchronous result FIFO with a registered head word, so dout is valid
// the cycle after a push into an empty buffer and stays put while not popped.
module smvm_out_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             push_ok, pop_ok;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign dout  = dout_q;

    always_comb begin
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // The next head is the word being written when the new read slot is
        // the one being filled this cycle; otherwise it comes from storage.
        dout_d = dout_q;
        if (count_d != '0) begin
            if (push_ok && (wr_ptr_q == rd_ptr_d)) dout_d = din;
            else                                   dout_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
        end
    end

endmodule

// File: rtl/smvm_row_accum.sv
// SMVM row accumulator: sums tagged partial sums into one saturated result per
// matrix row and streams the results out in row order through a small FIFO.
module smvm_row_accum
    import smvm_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [7:0]               rows,
    input  logic                     psum_valid,
    input  logic signed [PSUM_W-1:0] psum,
    input  logic                     row_end,
    output logic                     psum_ready,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic signed [OUT_W-1:0]  data_out,
    output logic                     busy,
    output logic                     done
);

    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(OUT_MAX);
    localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(OUT_MIN);

    smvm_state_e             state_q, state_d;
    logic [7:0]              rows_q, rows_d;
    logic [7:0]              row_cnt_q, row_cnt_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] sum;
    logic signed [OUT_W-1:0] sat_sum;
    logic                    done_q, done_d;
    logic                    xfer, push, pop;
    logic                    fifo_full, fifo_empty;
    logic [OUT_W-1:0]        fifo_dout;

    function automatic logic signed [OUT_W-1:0] sat(input logic signed [ACC_W-1:0] x);
        if (x > ACC_MAX)      return OUT_MAX;
        else if (x < ACC_MIN) return OUT_MIN;
        else                  return x[OUT_W-1:0];
    endfunction

    assign psum_ready = (state_q == ST_ACCUM) && !fifo_full;
    assign xfer       = psum_valid && psum_ready;
    assign sum        = acc_q + ACC_W'(psum);
    assign sat_sum    = sat(sum);
    assign push       = xfer && row_end;
    assign out_valid  = !fifo_empty;
    assign pop        = out_valid && out_ready;
    assign data_out   = fifo_dout;
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;

    always_comb begin
        state_d   = state_q;
        rows_d    = rows_q;
        row_cnt_d = row_cnt_q;
        acc_d     = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rows_d    = rows;
                    row_cnt_d = '0;
                    acc_d     = '0;
                    state_d   = (rows != '0) ? ST_ACCUM : ST_DONE;
                end
            end
            ST_ACCUM: begin
                if (xfer) begin
                    if (row_end) begin
                        acc_d     = '0;
                        row_cnt_d = row_cnt_q + 8'd1;
                        if (row_cnt_d == rows_q) state_d = ST_DRAIN;
                    end else begin
                        acc_d = sum;
                    end
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rows_q    <= '0;
            row_cnt_q <= '0;
            acc_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rows_q    <= rows_d;
            row_cnt_q <= row_cnt_d;
            acc_q     <= acc_d;
            done_q    <= done_d;
        end
    end

    smvm_out_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(OUT_W)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (push),
        .din  (sat_sum),
        .pop  (pop),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty)
    );

endmodule
